result_tx: RTL and testbench
============================

// Module: result_tx
// PURPOSE
//  Transmit end of the wide-bus/stream interface: the mirror of the kernel stream loader.
//  Captures wide result words from the compute array (GROUP_NB*RES_WIDTH*DEPTH_NB bits).
//  Serialises each word into STR_RES_WIDTH beats on a val/rdy/last output stream.
//  A cfg-bus write arms a transfer of N wide words; the final beat of the transfer is tagged last.
// PARAMETERS
//  CFG_DWIDTH     32   config data width
//  CFG_AWIDTH     5    config address width
//  STR_RES_WIDTH  64   output stream width; must divide RES_BUS_W; RATIO=RES_BUS_W/STR_RES_WIDTH must be >=2
//  GROUP_NB       4    result groups
//  RES_WIDTH      16   bits per result element, two's complement
//  DEPTH_NB       16   elements per group; RES_BUS_W = GROUP_NB*RES_WIDTH*DEPTH_NB (1024 at defaults, RATIO=16)
//  CNT_WIDTH      16   width of the word counter
// PORTS
//  clk           in   1              clock, single domain
//  rst           in   1              synchronous, active-high reset
//  cfg_data      in   CFG_DWIDTH     config payload
//  cfg_addr      in   CFG_AWIDTH     config register address
//  cfg_valid     in   1              config strobe
//  res_bus       in   RES_BUS_W      wide result word from compute array
//  res_val       in   1              res_bus valid
//  res_rdy       out  1              block accepts res_bus this cycle
//  str_res       out  STR_RES_WIDTH  output stream beat
//  str_res_val   out  1              beat valid
//  str_res_last  out  1              final beat of the armed transfer
//  str_res_rdy   in   1              downstream accepts beat
//  busy          out  1              transfer armed and not yet complete
// BEHAVIOUR
//  Reset: state=IDLE; res_rdy, str_res_val, str_res_last and busy=0; str_res=0; counters=0.
//  Reset mid-transfer aborts the transfer: all outputs return to their reset values on the next cycle.
//  FSM IDLE -> LOAD -> SHIFT -> (LOAD | IDLE).
//  IDLE: cfg_valid & cfg_addr==CFG_RES_TX & N!=0 -> LOAD, where N=cfg_data[CNT_WIDTH-1:0]; words_left=N; busy=1 from next cycle.
//    A cfg write with N=0 is ignored.
//  Config writes to CFG_RES_TX while busy=1 are ignored; any other cfg_addr is ignored in every state.
//  LOAD: res_rdy=1. On res_val&res_rdy: capture res_bus into the shift register, beat=0 -> SHIFT.
//  SHIFT: res_rdy=0, str_res_val=1, str_res=shift_reg[STR_RES_WIDTH-1:0] (LSB slice first).
//    On str_res_rdy: shift right by STR_RES_WIDTH and beat++.
//    On accepted beat RATIO-1: words_left--; if it reaches 0 -> IDLE (busy=0 next cycle), else -> LOAD.
//  str_res_last=1 only while beat==RATIO-1 and words_left==1, i.e. with str_res_val.
//  While str_res_val & !str_res_rdy: str_res and str_res_last hold stable (AXI-style; no retraction).
//  Latency: capture to first beat valid = 1 cycle. There is one LOAD bubble between consecutive words.
//  Output registers drive str_res and str_res_val; there is no combinational path from str_res_rdy to res_rdy.
// CONFIGURATION
//  Macro RESULT_TX_RELU_EN.
//   Defined: at capture, each RES_WIDTH element with its sign bit set is replaced by 0 (ReLU).
//     This adds no latency.
//   Undefined: res_bus is captured bit-exact.
// STRUCTURE
//  The CFG_RES_TX address constant is added to the shared cfg_parameters.vh alongside CFG_KER_WR/CFG_KER_RD.
//  RES_BUS_W and RATIO are localparams.
//  State encoding is a local to this block.
//  One sub-module: result_relu (combinational per-element clamp, instantiated only under RESULT_TX_RELU_EN).
//  The FSM, counters and shift register stay in result_tx.
// TESTING
//  1. cfg N=1, res_bus with element k = k -> 16 beats, LSB slice first; beat0=64'h0003_0002_0001_0000; last only on beat 15; busy=0 the cycle after.
//  2. cfg N=3, random 50% str_res_rdy -> 48 beats in order, data/last stable under stall, res_rdy high exactly 3 times.
//  3. cfg N=0, then res_val held high -> res_rdy, str_res_val and busy all stay 0.
//  4. cfg N=2, second CFG_RES_TX (N=5) mid-transfer -> ignored; exactly 32 beats, last on beat 31.
//  5. rst asserted during beat 7 of word 1 -> next cycle str_res_val=0, res_rdy=0, busy=0; a new cfg then runs a clean transfer.
//  6. Element 0 = 16'h8001, element 1 = 16'h7FFF -> beat0 low 32 bits are 32'h7FFF_0000 with RESULT_TX_RELU_EN, 32'h7FFF_8001 without.

Source files
------------

// File: rtl/result_tx_pkg.sv
// Shared constants for the result transmit block.
// CFG_RES_TX sits next to CFG_KER_WR/CFG_KER_RD in the cfg register map.
package result_tx_pkg;
  localparam int CFG_KER_WR = 1;
  localparam int CFG_KER_RD = 2;
  localparam int CFG_RES_TX = 3;
endpackage

// File: rtl/result_relu.sv
// Per-element ReLU clamp: negative two's-complement values become zero.
// Purely combinational; one instance per result element.
module result_relu
  import result_tx_pkg::*;
#(
  parameter int RES_WIDTH = 16
) (
  input  logic [RES_WIDTH-1:0] din,
  output logic [RES_WIDTH-1:0] dout
);
  assign dout = din[RES_WIDTH-1] ? '0 : din;
endmodule

// File: rtl/result_tx.sv
// Result transmit: captures wide result words and serialises them, LSB slice first,
// onto a val/rdy/last stream. Optional macro RESULT_TX_RELU_EN clamps negatives at capture.
module result_tx
  import result_tx_pkg::*;
#(
  parameter int CFG_DWIDTH    = 32,
  parameter int CFG_AWIDTH    = 5,
  parameter int STR_RES_WIDTH = 64,
  parameter int GROUP_NB      = 4,
  parameter int RES_WIDTH     = 16,
  parameter int DEPTH_NB      = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CFG_DWIDTH-1:0]                  cfg_data,
  input  logic [CFG_AWIDTH-1:0]                  cfg_addr,
  input  logic                                   cfg_valid,
  input  logic [GROUP_NB*RES_WIDTH*DEPTH_NB-1:0] res_bus,
  input  logic                                   res_val,
  output logic                                   res_rdy,
  output logic [STR_RES_WIDTH-1:0]               str_res,
  output logic                                   str_res_val,
  output logic                                   str_res_last,
  input  logic                                   str_res_rdy,
  output logic                                   busy
);
  localparam int RES_BUS_W = GROUP_NB*RES_WIDTH*DEPTH_NB;
  localparam int RATIO     = RES_BUS_W/STR_RES_WIDTH;
  localparam int BEAT_W    = $clog2(RATIO);
  localparam int ELEM_NB   = GROUP_NB*DEPTH_NB;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t               state, state_nxt;
  logic [RES_BUS_W-1:0] shift_reg, cap_bus;
  logic [BEAT_W-1:0]    beat;
  logic [CNT_WIDTH-1:0] words_left;
  logic                 arm, beat_end, last_word, unused_cfg;

  assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:CNT_WIDTH];
  assign arm        = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_RES_TX))
                      && (cfg_data[CNT_WIDTH-1:0] != '0);
  assign beat_end   = (beat == BEAT_W'(RATIO-1));
  assign last_word  = (words_left == CNT_WIDTH'(1));

`ifdef RESULT_TX_RELU_EN
  for (genvar e = 0; e < ELEM_NB; e++) begin : g_relu
    result_relu #(.RES_WIDTH(RES_WIDTH)) u_relu (
      .din  (res_bus[e*RES_WIDTH +: RES_WIDTH]),
      .dout (cap_bus[e*RES_WIDTH +: RES_WIDTH])
    );
  end
`else
  assign cap_bus = res_bus;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arm) state_nxt = LOAD;
      LOAD:    if (res_val) state_nxt = SHIFT;
      SHIFT:   if (str_res_rdy && beat_end) state_nxt = last_word ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs decode registered state, so str_res_rdy never reaches res_rdy.
  assign res_rdy      = (state == LOAD);
  assign str_res_val  = (state == SHIFT);
  assign str_res_last = (state == SHIFT) && beat_end && last_word;
  assign str_res      = shift_reg[STR_RES_WIDTH-1:0];
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      beat       <= '0;
      words_left <= '0;
    end else begin
      unique case (state)
        IDLE: if (arm) words_left <= cfg_data[CNT_WIDTH-1:0];
        LOAD: if (res_val) begin
          shift_reg <= cap_bus;
          beat      <= '0;
        end
        SHIFT: if (str_res_rdy) begin
          // Full drain shifts the register back to zero, so str_res idles at 0.
          shift_reg <= shift_reg >> STR_RES_WIDTH;
          beat      <= beat + 1'b1;
          if (beat_end) words_left <= words_left - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_result_tx.sv
// Self-checking bench for result_tx: random result words and stream backpressure,
// checked against a word-level model (slices of each captured word, optional ReLU).
module tb_result_tx;
  import result_tx_pkg::*;

  localparam int W     = 1024;
  localparam int SW    = 64;
  localparam int RATIO = W/SW;

  logic          clk = 0, rst = 1;
  logic [31:0]   cfg_data = '0;
  logic [4:0]    cfg_addr = '0;
  logic          cfg_valid = 0;
  logic [W-1:0]  res_bus = '0;
  logic          res_val = 0, res_rdy;
  logic [SW-1:0] str_res;
  logic          str_res_val, str_res_last, busy;
  logic          str_res_rdy = 1;

  result_tx dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .res_bus(res_bus), .res_val(res_val), .res_rdy(res_rdy), .str_res(str_res),
    .str_res_val(str_res_val), .str_res_last(str_res_last), .str_res_rdy(str_res_rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, rdy_pct = 100;
  bit rand_words = 1;
  logic [W-1:0]  words_q[$];
  logic [SW-1:0] got_data[$];
  bit            got_last[$];
  int  n_rdy, n_stall_viol, last_acc_cyc, cap_cyc, first_val_cyc;
  bit  any_busy, any_val, pend_stall;
  logic [SW-1:0] prev_data;
  logic          prev_last;

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: a captured word leaves as RATIO slices, LSB first, after optional ReLU.
  function automatic logic [SW-1:0] model_beat(input logic [W-1:0] w, input int j);
    logic [W-1:0] r;
    r = w;
`ifdef RESULT_TX_RELU_EN
    for (int e = 0; e < W/16; e++) if (w[e*16+15]) r[e*16 +: 16] = '0;
`endif
    return r[j*SW +: SW];
  endfunction

  task automatic clear();
    words_q.delete(); got_data.delete(); got_last.delete();
    n_rdy = 0; n_stall_viol = 0; last_acc_cyc = -1; cap_cyc = -1; first_val_cyc = -1;
    any_busy = 0; any_val = 0; pend_stall = 0;
  endtask

  // One clock: record handshakes seen just before the edge, then update stimulus after it.
  task automatic step();
    bit ar, ab;
    ar = res_val && res_rdy;
    ab = str_res_val && str_res_rdy;
    if (ar) begin words_q.push_back(res_bus); if (cap_cyc < 0) cap_cyc = cyc; end
    if (str_res_val && first_val_cyc < 0) first_val_cyc = cyc;
    if (ab) begin
      got_data.push_back(str_res); got_last.push_back(str_res_last);
      if (str_res_last) last_acc_cyc = cyc;
    end
    if (res_rdy) n_rdy++;
    any_busy |= busy; any_val |= str_res_val;
    if (pend_stall && (!str_res_val || str_res !== prev_data || str_res_last !== prev_last))
      n_stall_viol++;
    pend_stall = str_res_val && !str_res_rdy;
    prev_data = str_res; prev_last = str_res_last;
    @(posedge clk); #1;
    cyc++;
    if (ar && rand_words) res_bus = rand_word();
    str_res_rdy = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] n);
    cfg_addr = a; cfg_data = n; cfg_valid = 1;
    step();
    cfg_valid = 0;
  endtask

  task automatic run_until_idle(input int budget, output bit timed_out);
    int k = 0;
    while (busy && k < budget) begin step(); k++; end
    timed_out = busy;
  endtask

  task automatic test_reset();
    rst = 1; res_val = 1;
    step(); step();
    n_chk++;
    if ({res_rdy, str_res_val, str_res_last, busy} !== 4'b0 || str_res !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy/val/last/busy=%b str_res=%h, expected 0000/0",
               {res_rdy, str_res_val, str_res_last, busy}, str_res);
    end
    rst = 0; res_val = 0;
    step();
  endtask

  task automatic test_single_word();
    bit to;
    clear(); rand_words = 0; rdy_pct = 100; res_val = 1;
    for (int k = 0; k < 64; k++) res_bus[k*16 +: 16] = 16'(k);
    cfg_write(5'(CFG_RES_TX), 1);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_armed: got %b expected 1", busy); end
    run_until_idle(200, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL t1_timeout: busy still %b after 200 cycles", busy); end
    n_chk++; if (got_data.size() != RATIO) begin n_fail++; $display("FAIL t1_beats: got %0d expected %0d", got_data.size(), RATIO); end
    n_chk++; if (got_data.size() > 0 && got_data[0] !== 64'h0003_0002_0001_0000) begin
      n_fail++; $display("FAIL t1_beat0: got %h expected 0003000200010000", got_data[0]); end
    for (int j = 0; j < got_data.size() && words_q.size() > 0; j++) begin
      n_chk++;
      if (got_data[j] !== model_beat(words_q[0], j) || got_last[j] !== (j == RATIO-1)) begin
        n_fail++; $display("FAIL t1_beat%0d: got %h/%b expected %h/%b", j, got_data[j], got_last[j],
                           model_beat(words_q[0], j), (j == RATIO-1)); end
    end
    n_chk++; if (first_val_cyc != cap_cyc + 1) begin n_fail++;
      $display("FAIL t1_latency: first beat at cycle %0d expected %0d", first_val_cyc, cap_cyc + 1); end
    n_chk++; if (cyc != last_acc_cyc + 1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL t1_busy_drop: busy=%b at cycle %0d, last beat at %0d", busy, cyc, last_acc_cyc); end
    res_val = 0; rand_words = 1;
  endtask

  task automatic test_backpressure();
    bit to;
    int total;
    clear(); rdy_pct = 50; res_val = 1; res_bus = rand_word();
    cfg_write(5'(CFG_RES_TX), 3);
    run_until_idle(2000, to);
    total = 3*RATIO;
    n_chk++; if (to) begin n_fail++; $display("FAIL t2_timeout: busy still set"); end
    n_chk++; if (got_data.size() != total || words_q.size() != 3) begin n_fail++;
      $display("FAIL t2_counts: got %0d beats/%0d words expected %0d/3", got_data.size(), words_q.size(), total); end
    for (int j = 0; j < got_data.size() && j/RATIO < words_q.size(); j++) begin
      n_chk++;
      if (got_data[j] !== model_beat(words_q[j/RATIO], j%RATIO) || got_last[j] !== (j == total-1)) begin
        n_fail++; $display("FAIL t2_beat%0d: got %h/%b expected %h/%b", j, got_data[j], got_last[j],
                           model_beat(words_q[j/RATIO], j%RATIO), (j == total-1)); end
    end
    n_chk++; if (n_stall_viol != 0) begin n_fail++; $display("FAIL t2_stall_stable: got %0d changes under stall expected 0", n_stall_viol); end
    n_chk++; if (n_rdy != 3) begin n_fail++; $display("FAIL t2_res_rdy: got %0d cycles expected 3", n_rdy); end
    rdy_pct = 100; res_val = 0;
  endtask

  task automatic test_ignored_cfg();
    clear(); res_val = 1;
    cfg_write(5'(CFG_RES_TX), 0);
    cfg_write(5'(CFG_RES_TX + 1), 4);
    for (int i = 0; i < 20; i++) step();
    n_chk++; if (n_rdy != 0 || any_val || any_busy) begin n_fail++;
      $display("FAIL t3_ignored: got rdy_cycles=%0d val=%b busy=%b expected 0/0/0", n_rdy, any_val, any_busy); end
    res_val = 0;
  endtask

  task automatic test_rearm_ignored();
    bit to;
    clear(); res_val = 1; res_bus = rand_word();
    cfg_write(5'(CFG_RES_TX), 2);
    for (int i = 0; i < 10; i++) step();
    cfg_write(5'(CFG_RES_TX), 5);
    run_until_idle(500, to);
    n_chk++; if (to || got_data.size() != 2*RATIO) begin n_fail++;
      $display("FAIL t4_beats: got %0d beats (timeout=%b) expected 32", got_data.size(), to); end
    for (int j = 0; j < got_data.size() && j/RATIO < words_q.size(); j++) begin
      n_chk++;
      if (got_data[j] !== model_beat(words_q[j/RATIO], j%RATIO) || got_last[j] !== (j == 2*RATIO-1)) begin
        n_fail++; $display("FAIL t4_beat%0d: got %h/%b expected %h/%b", j, got_data[j], got_last[j],
                           model_beat(words_q[j/RATIO], j%RATIO), (j == 2*RATIO-1)); end
    end
    res_val = 0;
  endtask

  task automatic test_reset_abort();
    bit to;
    int k = 0;
    clear(); res_val = 1; res_bus = rand_word();
    cfg_write(5'(CFG_RES_TX), 2);
    while (got_data.size() < RATIO + 7 && k < 200) begin step(); k++; end
    n_chk++; if (str_res_val !== 1'b1 || k >= 200) begin n_fail++;
      $display("FAIL t5_reach_beat7: val=%b after %0d cycles expected 1", str_res_val, k); end
    rst = 1;
    step();
    n_chk++;
    if ({res_rdy, str_res_val, str_res_last, busy} !== 4'b0 || str_res !== '0) begin n_fail++;
      $display("FAIL t5_abort: got rdy/val/last/busy=%b str_res=%h expected 0000/0",
               {res_rdy, str_res_val, str_res_last, busy}, str_res); end
    rst = 0;
    step();
    clear();
    cfg_write(5'(CFG_RES_TX), 1);
    run_until_idle(200, to);
    n_chk++; if (to || got_data.size() != RATIO || words_q.size() != 1) begin n_fail++;
      $display("FAIL t5_rerun: got %0d beats (timeout=%b) expected 16", got_data.size(), to); end
    for (int j = 0; j < got_data.size() && words_q.size() > 0; j++) begin
      n_chk++;
      if (got_data[j] !== model_beat(words_q[0], j) || got_last[j] !== (j == RATIO-1)) begin
        n_fail++; $display("FAIL t5_beat%0d: got %h/%b expected %h/%b", j, got_data[j], got_last[j],
                           model_beat(words_q[0], j), (j == RATIO-1)); end
    end
    res_val = 0;
  endtask

  task automatic test_relu();
    bit to;
    logic [31:0] exp_lo;
`ifdef RESULT_TX_RELU_EN
    exp_lo = 32'h7FFF_0000;
`else
    exp_lo = 32'h7FFF_8001;
`endif
    clear(); rand_words = 0; res_val = 1;
    res_bus = '0; res_bus[15:0] = 16'h8001; res_bus[31:16] = 16'h7FFF;
    cfg_write(5'(CFG_RES_TX), 1);
    run_until_idle(200, to);
    n_chk++; if (to || got_data.size() == 0 || got_data[0][31:0] !== exp_lo) begin n_fail++;
      $display("FAIL t6_relu: got %h expected %h", (got_data.size() > 0) ? got_data[0][31:0] : 32'hx, exp_lo); end
    res_val = 0; rand_words = 1;
  endtask

  initial begin
    #1;
    clear();
    test_reset();
    test_single_word();
    test_backpressure();
    test_ignored_cfg();
    test_rearm_ignored();
    test_reset_abort();
    test_relu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
